tc_cfg_seq: RTL and testbench



---
 rtl/tc_cfg_seq.sv | 194 +++++++++++++++++++
 tb/tb_tc_cfg_seq.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_cfg_seq.sv
// Bus-master sequencer: programs the 8-bit timer, services n compare interrupts, then stops it.
// Define TCSEQ_ABORT_EN to honour the abort input; otherwise abort is ignored.
module tc_cfg_seq #(
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 1000,
  parameter int TO_W    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] cfg_mode,
  input  logic [7:0] cfg_clksel,
  input  logic [7:0] cfg_ocra,
  input  logic [7:0] cfg_timsk,
  input  logic [7:0] n_events,
  output logic [7:0] addr,
  output logic [7:0] wdata,
  output logic       write,
  output logic       read,
  input  logic [7:0] rdata,
  input  logic       irq,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] evt_count,
  output logic [7:0] last_tcnt
);

  localparam logic [7:0] A_TIFR  = 8'h15;
  localparam logic [7:0] A_TCCRA = 8'h24;
  localparam logic [7:0] A_TCCRB = 8'h25;
  localparam logic [7:0] A_TCNT  = 8'h26;
  localparam logic [7:0] A_OCRA  = 8'h27;
  localparam logic [7:0] A_TIMSK = 8'h6E;

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_WAIT, S_RD, S_RDW, S_CLR, S_STOP, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [7:0]      mode_q, mode_d, clksel_q, clksel_d, ocra_q, ocra_d, timsk_q, timsk_d;
  logic [7:0]      nev_q, nev_d, evt_q, evt_d, tcnt_q, tcnt_d;
  logic            err_q, err_d;

`ifdef TCSEQ_ABORT_EN
  logic abort_act;
  assign abort_act = abort && (state_q inside {S_CFG, S_WAIT, S_RD, S_RDW, S_CLR});
`else
  logic unused_abort;
  assign unused_abort = abort;
`endif

  assign busy      = !(state_q inside {S_IDLE, S_DONE});
  assign err       = err_q;
  assign evt_count = evt_q;
  assign last_tcnt = tcnt_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    clksel_d = clksel_q;
    ocra_d   = ocra_q;
    timsk_d  = timsk_q;
    nev_d    = nev_q;
    evt_d    = evt_q;
    tcnt_d   = tcnt_q;
    err_d    = err_q;
    addr     = 8'h00;
    wdata    = 8'h00;
    write    = 1'b0;
    read     = 1'b0;
    done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d   = cfg_mode;
          clksel_d = cfg_clksel;
          ocra_d   = cfg_ocra;
          timsk_d  = cfg_timsk;
          nev_d    = n_events;
          evt_d    = 8'h00;
          err_d    = 1'b0;
          idx_d    = 3'd0;
          state_d  = S_CFG;
        end
      end
      S_CFG: begin
        // Timer is stopped first so the remaining registers are written while it is frozen
        write = 1'b1;
        case (idx_q)
          3'd0:    begin addr = A_TCCRB; wdata = 8'h00;    end
          3'd1:    begin addr = A_TCCRA; wdata = mode_q;   end
          3'd2:    begin addr = A_OCRA;  wdata = ocra_q;   end
          3'd3:    begin addr = A_TCNT;  wdata = 8'h00;    end
          3'd4:    begin addr = A_TIFR;  wdata = 8'h07;    end
          3'd5:    begin addr = A_TIMSK; wdata = timsk_q;  end
          default: begin addr = A_TCCRB; wdata = clksel_q; end
        endcase
        if (idx_q == 3'd6) begin
          cnt_d   = '0;
          state_d = (nev_q == 8'h00) ? S_STOP : S_WAIT;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      S_WAIT: begin
        if (irq) begin
          state_d = S_RD;
        end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RD: begin
        read    = 1'b1;
        addr    = A_TCNT;
        cnt_d   = '0;
        state_d = S_RDW;
      end
      S_RDW: begin
        if (cnt_q == TO_W'(RD_LAT - 1)) begin
          tcnt_d  = rdata;
          state_d = S_CLR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CLR: begin
        write   = 1'b1;
        addr    = A_TIFR;
        wdata   = 8'h07;
        evt_d   = evt_q + 8'd1;
        cnt_d   = '0;
        state_d = (evt_d == nev_q) ? S_STOP : S_WAIT;
      end
      S_STOP: begin
        write   = 1'b1;
        addr    = A_TCCRB;
        wdata   = 8'h00;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef TCSEQ_ABORT_EN
    // Any strobe issued this cycle still completes; only the successor state is overridden
    if (abort_act) begin
      state_d = S_STOP;
      err_d   = err_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= 3'd0;
      cnt_q    <= '0;
      mode_q   <= 8'h00;
      clksel_q <= 8'h00;
      ocra_q   <= 8'h00;
      timsk_q  <= 8'h00;
      nev_q    <= 8'h00;
      evt_q    <= 8'h00;
      tcnt_q   <= 8'h00;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      clksel_q <= clksel_d;
      ocra_q   <= ocra_d;
      timsk_q  <= timsk_d;
      nev_q    <= nev_d;
      evt_q    <= evt_d;
      tcnt_q   <= tcnt_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_tc_cfg_seq.sv
// Testbench for tc_cfg_seq: scoreboard of expected bus strobes plus reactive timer models.
// Instance a uses RD_LAT=1, instance b uses RD_LAT=3; both use TIMEOUT=50.
module tb_tc_cfg_seq;

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst = 1'b1;
  logic       start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
  logic [7:0] cfg_mode = 8'h00, cfg_clksel = 8'h00, cfg_ocra = 8'h00, cfg_timsk = 8'h00;
  logic [7:0] n_events = 8'h00;
  logic [7:0] rdata_a = 8'h00, rdata_b = 8'h00;
  logic       irq_a = 1'b0, irq_b = 1'b0;
  logic [7:0] addr_a, wdata_a, evt_a, tcnt_a, addr_b, wdata_b, evt_b, tcnt_b;
  logic       write_a, read_a, busy_a, done_a, err_a;
  logic       write_b, read_b, busy_b, done_b, err_b;

  tc_cfg_seq #(.RD_LAT(1), .TIMEOUT(50), .TO_W(16)) u_dut (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
    .cfg_mode(cfg_mode), .cfg_clksel(cfg_clksel), .cfg_ocra(cfg_ocra), .cfg_timsk(cfg_timsk),
    .n_events(n_events), .addr(addr_a), .wdata(wdata_a), .write(write_a), .read(read_a),
    .rdata(rdata_a), .irq(irq_a), .busy(busy_a), .done(done_a), .err(err_a),
    .evt_count(evt_a), .last_tcnt(tcnt_a)
  );

  tc_cfg_seq #(.RD_LAT(3), .TIMEOUT(50), .TO_W(16)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
    .cfg_mode(cfg_mode), .cfg_clksel(cfg_clksel), .cfg_ocra(cfg_ocra), .cfg_timsk(cfg_timsk),
    .n_events(n_events), .addr(addr_b), .wdata(wdata_b), .write(write_b), .read(read_b),
    .rdata(rdata_b), .irq(irq_b), .busy(busy_b), .done(done_b), .err(err_b),
    .evt_count(evt_b), .last_tcnt(tcnt_b)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  int   strobe_cnt_a = 0, done_cnt_a = 0;
  bit   irq_en = 1'b0;
  int   irq_cd = 0, rd_cnt = 0, age_b = 0;
  bit   rd_pend_a = 1'b0, pend_clr = 1'b0;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic rd, input logic wr, input logic [7:0] a,
                          input logic [7:0] d, input int c);
    exp_t e;
    e.rd = rd; e.wr = wr; e.addr = a; e.data = d; e.cyc = c;
    sb_q.push_back(e);
  endtask

  // Config writes as the timer expects them; first write lands the cycle after start is sampled
  task automatic push_cfg(input int t0, input bit timed, input int nwr, input logic [7:0] m,
                          input logic [7:0] cs, input logic [7:0] oc, input logic [7:0] tm);
    logic [7:0] a [7];
    logic [7:0] d [7];
    a = '{8'h25, 8'h24, 8'h27, 8'h26, 8'h15, 8'h6E, 8'h25};
    d = '{8'h00, m, oc, 8'h00, 8'h07, tm, cs};
    for (int i = 0; i < nwr; i++) push_exp(1'b0, 1'b1, a[i], d[i], timed ? t0 + 1 + i : -1);
  endtask

  task automatic apply_stimulus(input logic [7:0] m, input logic [7:0] cs, input logic [7:0] oc,
                                input logic [7:0] tm, input logic [7:0] nev);
    cfg_mode = m; cfg_clksel = cs; cfg_ocra = oc; cfg_timsk = tm; n_events = nev;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    cfg_mode = ~m; cfg_clksel = ~cs; cfg_ocra = ~oc; cfg_timsk = ~tm; n_events = 8'hFF;
  endtask

  task automatic wait_done(input int budget, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_a) begin
        dcyc = cyc;
        check_output("busy_low_at_done", 64'(busy_a), 64'd0);
        break;
      end
    end
    check_output("done_within_budget", 64'(dcyc >= 0), 64'd1);
    tick();
  endtask

  // Bus monitor for instance a, followed by its timer model (irq and TCNT read data)
  always @(negedge clk) begin
    if (done_a) done_cnt_a++;
    if (read_a || write_a) begin
      strobe_cnt_a++;
      check_output("one_strobe", 64'(read_a & write_a), 64'd0);
      check_output("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        check_output("strobe", {read_a, write_a, addr_a, wdata_a},
                     {mon_e.rd, mon_e.wr, mon_e.addr, mon_e.data});
        if (mon_e.cyc >= 0) check_output("strobe_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
      if (write_a && addr_a == 8'h15 && pend_clr) begin
        check_output("last_tcnt_at_clr", 64'(tcnt_a), 64'(8'h04 + 8'(rd_cnt)));
        pend_clr = 1'b0;
      end
      if (read_a) pend_clr = 1'b1;
    end else begin
      check_output("idle_bus", {addr_a, wdata_a}, 64'd0);
    end

    if (rst) begin
      irq_a = 1'b0; irq_cd = 0; rd_cnt = 0; rd_pend_a = 1'b0; pend_clr = 1'b0; rdata_a = 8'hEE;
    end else begin
      if (start_a && !busy_a) rd_cnt = 0;
      if (write_a && addr_a == 8'h15) begin
        irq_a  = 1'b0;
        irq_cd = irq_en ? 20 : 0;
      end else if (irq_cd > 0) begin
        irq_cd--;
        if (irq_cd == 0) irq_a = 1'b1;
      end
      if (rd_pend_a) begin
        rdata_a   = 8'h04 + 8'(rd_cnt);
        rd_pend_a = 1'b0;
      end else begin
        rdata_a = 8'hEE;
      end
      if (read_a) begin
        rd_cnt++;
        rd_pend_a = 1'b1;
      end
    end
  end

  // Instance b: a wrong value is visible 2 cycles after the read, the real one at 3
  always @(negedge clk) begin
    case (age_b)
      1:       begin rdata_b = 8'hEE; age_b = 2; end
      2:       begin rdata_b = 8'hA5; age_b = 3; end
      3:       begin rdata_b = 8'h3C; age_b = 0; end
      default: rdata_b = 8'hEE;
    endcase
    if (read_b) age_b = 1;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0, dc, d0, s0;

    repeat (3) tick();
    check_output("rst_outputs",
                 {addr_a, wdata_a, write_a, read_a, busy_a, done_a, err_a, evt_a, tcnt_a}, 64'd0);
    rst = 1'b0;
    tick();

    // n_events=0: seven timed config writes, stop write, done
    d0 = done_cnt_a;
    t0 = cyc;
    push_cfg(t0, 1'b1, 7, 8'h02, 8'h03, 8'h18, 8'h02);
    push_exp(1'b0, 1'b1, 8'h25, 8'h00, t0 + 8);
    apply_stimulus(8'h02, 8'h03, 8'h18, 8'h02, 8'h00);
    check_output("busy_after_start", 64'(busy_a), 64'd1);
    wait_done(100, dc);
    check_output("done_cycle_n0", 64'(dc), 64'(t0 + 9));
    check_output("evt_n0", 64'(evt_a), 64'd0);
    check_output("err_n0", 64'(err_a), 64'd0);
    repeat (3) tick();
    check_output("done_once_n0", 64'(done_cnt_a - d0), 64'd1);
    check_output("sb_drained_n0", 64'(sb_q.size()), 64'd0);

    // n_events=3 with irq 20 cycles after each TIFR clear, plus a start while busy
    irq_en = 1'b1;
    d0 = done_cnt_a;
    push_cfg(cyc, 1'b0, 7, 8'h11, 8'h05, 8'h40, 8'h02);
    for (int i = 0; i < 3; i++) begin
      push_exp(1'b1, 1'b0, 8'h26, 8'h00, -1);
      push_exp(1'b0, 1'b1, 8'h15, 8'h07, -1);
    end
    push_exp(1'b0, 1'b1, 8'h25, 8'h00, -1);
    apply_stimulus(8'h11, 8'h05, 8'h40, 8'h02, 8'h03);
    repeat (15) tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done(400, dc);
    check_output("last_tcnt_n3", 64'(tcnt_a), 64'h07);
    check_output("evt_n3", 64'(evt_a), 64'd3);
    check_output("err_n3", 64'(err_a), 64'd0);
    repeat (3) tick();
    check_output("done_once_n3", 64'(done_cnt_a - d0), 64'd1);
    check_output("sb_drained_n3", 64'(sb_q.size()), 64'd0);
    repeat (30) tick();

    // Timeout: irq never arrives, 50 WAIT cycles then stop
    irq_en = 1'b0;
    t0 = cyc;
    push_cfg(t0, 1'b1, 7, 8'h00, 8'h01, 8'h10, 8'h02);
    push_exp(1'b0, 1'b1, 8'h25, 8'h00, t0 + 58);
    apply_stimulus(8'h00, 8'h01, 8'h10, 8'h02, 8'h02);
    check_output("evt_cleared_on_start", 64'(evt_a), 64'd0);
    wait_done(200, dc);
    check_output("done_cycle_timeout", 64'(dc), 64'(t0 + 59));
    check_output("err_timeout", 64'(err_a), 64'd1);
    check_output("evt_timeout", 64'(evt_a), 64'd0);
    repeat (5) tick();
    check_output("err_sticky", 64'(err_a), 64'd1);

    // Reset held 3 cycles in WAIT abandons the run without a stop write
    push_cfg(cyc, 1'b0, 7, 8'h01, 8'h02, 8'h03, 8'h04);
    apply_stimulus(8'h01, 8'h02, 8'h03, 8'h04, 8'h02);
    check_output("err_cleared_on_start", 64'(err_a), 64'd0);
    repeat (20) tick();
    rst = 1'b1;
    repeat (3) tick();
    check_output("rst_mid_wait_outputs",
                 {addr_a, wdata_a, write_a, read_a, busy_a, done_a, err_a, evt_a, tcnt_a}, 64'd0);
    rst = 1'b0;
    s0 = strobe_cnt_a;
    d0 = done_cnt_a;
    repeat (10) tick();
    check_output("no_strobe_after_rst", 64'(strobe_cnt_a - s0), 64'd0);
    check_output("no_done_after_rst", 64'(done_cnt_a - d0), 64'd0);
    check_output("sb_empty_after_rst", 64'(sb_q.size()), 64'd0);

    irq_en = 1'b1;
    push_cfg(cyc, 1'b0, 7, 8'h0A, 8'h0B, 8'h0C, 8'h0D);
    push_exp(1'b1, 1'b0, 8'h26, 8'h00, -1);
    push_exp(1'b0, 1'b1, 8'h15, 8'h07, -1);
    push_exp(1'b0, 1'b1, 8'h25, 8'h00, -1);
    apply_stimulus(8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h01);
    wait_done(200, dc);
    check_output("evt_after_rst_run", 64'(evt_a), 64'd1);
    check_output("last_tcnt_after_rst_run", 64'(tcnt_a), 64'h05);
    irq_en = 1'b0;
    repeat (30) tick();

    // Abort pulse during the 4th config write
    t0 = cyc;
`ifdef TCSEQ_ABORT_EN
    push_cfg(t0, 1'b1, 4, 8'h02, 8'h03, 8'h18, 8'h02);
    push_exp(1'b0, 1'b1, 8'h25, 8'h00, t0 + 5);
`else
    push_cfg(t0, 1'b1, 7, 8'h02, 8'h03, 8'h18, 8'h02);
    push_exp(1'b0, 1'b1, 8'h25, 8'h00, t0 + 8);
`endif
    apply_stimulus(8'h02, 8'h03, 8'h18, 8'h02, 8'h00);
    repeat (3) tick();
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    wait_done(100, dc);
`ifdef TCSEQ_ABORT_EN
    check_output("done_cycle_abort", 64'(dc), 64'(t0 + 6));
`else
    check_output("done_cycle_abort", 64'(dc), 64'(t0 + 9));
`endif
    check_output("err_abort", 64'(err_a), 64'd0);
    check_output("sb_drained_abort", 64'(sb_q.size()), 64'd0);

    // RD_LAT=3 instance: only the value valid 3 cycles after the read is captured
    cfg_mode = 8'h02; cfg_clksel = 8'h03; cfg_ocra = 8'h18; cfg_timsk = 8'h02; n_events = 8'h01;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    repeat (12) tick();
    irq_b = 1'b1;
    dc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (write_b && addr_b == 8'h15) irq_b = 1'b0;
      if (done_b) begin
        dc = cyc;
        break;
      end
    end
    check_output("done_b_within_budget", 64'(dc >= 0), 64'd1);
    tick();
    check_output("last_tcnt_rdlat3", 64'(tcnt_b), 64'h3C);
    check_output("evt_rdlat3", 64'(evt_b), 64'd1);
    check_output("err_rdlat3", 64'(err_b), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
